// File: rtl/cpu19_pkg.sv
// Shared types and widths for the 19-bit CPU register-file write path.
// Holds the write-request and LU holding-entry types plus the pipeline writeback data mux.
package cpu19_pkg;

  localparam int DATA_W         = 19;
  localparam int RADDR_W        = 3;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int STARVE_MAX_DEF = 4;

  typedef logic [RADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0]  rf_data_t;

  typedef struct packed {
    logic     we;
    rf_addr_t waddr;
    rf_data_t wdata;
  } wb_req_t;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t data;
  } lu_entry_t;

  function automatic rf_data_t sel_wb_data(input logic memtoreg,
                                           input rf_data_t rdata,
                                           input rf_data_t alu_out);
    return memtoreg ? rdata : alu_out;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the MEM/WB writeback, long-latency-unit and register-file write signals.
// master = upstream pipeline/LU/regfile side, slave = the arbiter.
interface wb_port_arbiter_if;
  import cpu19_pkg::*;

  logic     wb_regwrite;
  logic     wb_memtoreg;
  rf_data_t wb_rdata;
  rf_data_t wb_out;
  rf_addr_t wb_rd;

  logic     lu_valid;
  rf_data_t lu_data;
  rf_addr_t lu_rd;
  logic     lu_ready;

  logic     pipe_stall;

  logic     rf_we;
  rf_addr_t rf_waddr;
  rf_data_t rf_wdata;

  modport master (
    output wb_regwrite, wb_memtoreg, wb_rdata, wb_out, wb_rd,
    output lu_valid, lu_data, lu_rd,
    input  lu_ready, pipe_stall,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_regwrite, wb_memtoreg, wb_rdata, wb_out, wb_rd,
    input  lu_valid, lu_data, lu_rd,
    output lu_ready, pipe_stall,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_hold_fifo.sv
// Small holding FIFO for long-latency-unit results awaiting the register-file write port.
// DEPTH must be a power of two (>=2) so the pointers wrap by natural overflow.
module wb_hold_fifo
  import cpu19_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  lu_entry_t              din,
  output lu_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lu_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, LU results drain from a FIFO.
// Optional starvation guard (pipe_stall) is built only when WB_ARB_STARVE_GUARD_EN is defined.
module wb_port_arbiter
  import cpu19_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);

  lu_entry_t                  lu_in;
  lu_entry_t                  head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       push;
  logic                       pop;
  logic                       stall;
  logic                       pipe_req;
  rf_data_t                   pipe_data;
  wb_req_t                    next_req;
  wb_req_t                    rf_q;

  assign lu_in     = '{rd: bus.lu_rd, data: bus.lu_data};
  assign push      = bus.lu_valid && !fifo_full;
  assign pipe_req  = bus.wb_regwrite && !stall;
  assign pop       = !pipe_req && !fifo_empty;
  assign pipe_data = sel_wb_data(bus.wb_memtoreg, bus.wb_rdata, bus.wb_out);

  wb_hold_fifo #(.DEPTH(FIFO_DEPTH)) u_hold_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (lu_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_cnt;

  // Counts how long the FIFO head has been passed over; saturates so the stall stays asserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  assign stall = (fifo_count != '0) && (starve_cnt == SC_W'(STARVE_MAX));
`else
  logic unused_count;

  assign stall        = 1'b0;
  assign unused_count = ^fifo_count;
`endif

  // Address/data hold their last value when nothing is granted; only the enable drops.
  always_comb begin
    next_req    = rf_q;
    next_req.we = 1'b0;
    if (pipe_req) begin
      next_req = '{we: 1'b1, waddr: bus.wb_rd, wdata: pipe_data};
    end else if (!fifo_empty) begin
      next_req = '{we: 1'b1, waddr: head.rd, wdata: head.data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else begin
      rf_q <= next_req;
    end
  end

  assign bus.lu_ready   = !fifo_full;
  assign bus.pipe_stall = stall;
  assign bus.rf_we      = rf_q.we;
  assign bus.rf_waddr   = rf_q.waddr;
  assign bus.rf_wdata   = rf_q.wdata;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port of the 19-bit pipelined CPU.
- Shares that port between two sources:
  - the in-order writeback from the MEM/WB pipeline register;
  - a long-latency unit (multiply/divide) that returns results out of band.
- Pipeline writes have priority. LU results wait in a small holding FIFO. A starvation guard can freeze the pipeline so a held LU result can drain.

Parameters:
- DATA_W, 19, register/data width.
- RADDR_W, 3, register address width (8 registers).
- FIFO_DEPTH, 2, LU holding-FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, cycles a non-empty FIFO head may wait before pipe_stall asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- wb_regwrite  in  1  MEM/WB stage requests a register write.
- wb_memtoreg  in  1  1: write wb_rdata; 0: write wb_out.
- wb_rdata  in  DATA_W  memory read data from MEM/WB.
- wb_out  in  DATA_W  ALU result from MEM/WB.
- wb_rd  in  RADDR_W  destination register from MEM/WB.
- lu_valid  in  1  LU result available.
- lu_data  in  DATA_W  LU result data.
- lu_rd  in  RADDR_W  LU destination register.
- lu_ready  out  1  arbiter accepts LU result this cycle.
- pipe_stall  out  1  freeze IF..MEM/WB this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  RADDR_W  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset (rst_n=0 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO emptied; starve_cnt=0.
  - lu_ready=1 the cycle after reset; pipe_stall=0.
  - Reset mid-operation discards any held LU results; no write issues.
- LU accept: push when lu_valid && lu_ready.
  - lu_ready = !full, purely from the registered count.
  - No push while full, even if a pop happens the same cycle.
- Pipeline request: pipe_req = wb_regwrite && !pipe_stall. Pipeline write data = wb_memtoreg ? wb_rdata : wb_out.
- Grant, evaluated each cycle:
  - pipe_req: grant pipeline.
  - else if FIFO non-empty: grant FIFO head and pop.
  - else: no grant.
- Output timing: the granted write appears on rf_we/rf_waddr/rf_wdata at the next posedge (1-cycle latency). rf_we=0 in any cycle with no grant; rf_waddr/rf_wdata hold their last values.
- LU latency: no bypass, so lu_valid to rf_we is at least 2 cycles (push, then pop).
- starve_cnt:
  - reset to 0 whenever the FIFO is empty or the head is popped;
  - else increments, saturating at STARVE_MAX.
- pipe_stall = FIFO non-empty && starve_cnt==STARVE_MAX (combinational from registered state).
  - While pipe_stall=1, upstream holds MEM/WB, and the wb_* request is ignored that cycle. It is presented again next cycle and written then, so there is no loss and no double write.
- Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- Write ordering (WAW/RAW between LU and pipeline to the same rd) belongs to issue logic. The arbiter writes in grant order only.

Optional Feature:
- Macro WB_ARB_STARVE_GUARD_EN.
- Defined: starvation counter and pipe_stall behave as above.
- Undefined: counter is not built and pipe_stall is tied 0. The FIFO drains only in cycles with wb_regwrite=0, and LU results may wait indefinitely.

Decomposition:
- Shared package cpu19_pkg holds:
  - DATA_W=19 and RADDR_W=3;
  - typedef wb_req_t {we, waddr, wdata};
  - typedef rf_addr_t.
- Sub-module wb_hold_fifo: parameterised FIFO_DEPTH, synchronous active-low reset, push/pop/full/empty/count ports, storing {rd, data}.

Test Plan:
- Reset:
  - drive rst_n=0 for 2 cycles with wb_regwrite=1, lu_valid=1 → rf_we=0, rf_wdata=0, pipe_stall=0;
  - lu_ready=1 the cycle after release.
- Pipeline only:
  - wb_regwrite=1, wb_memtoreg=1, wb_rdata=19'h1A5A5, wb_out=19'h15A5A, wb_rd=3'b101 → next cycle rf_we=1, rf_waddr=5, rf_wdata=19'h1A5A5;
  - same with wb_memtoreg=0 → rf_wdata=19'h15A5A.
- LU only: wb_regwrite=0, one lu_valid pulse with lu_data=19'h7FFFF, lu_rd=2 → rf_we=1, rf_waddr=2, rf_wdata=19'h7FFFF exactly 2 cycles later.
- Contention:
  - wb_regwrite=1 every cycle; push LU result 19'h00123 to rd 3;
  - → pipeline writes for STARVE_MAX=4 cycles, then pipe_stall=1 for 1 cycle with the LU write (rd 3, 19'h00123) the next cycle;
  - the stalled pipeline write appears the cycle after, unduplicated.
- FIFO full: 3 back-to-back LU pushes while wb_regwrite=1 → lu_ready=0 after 2 pushes, third held until a pop; all three written in push order.
- Macro undefined: repeat contention → pipe_stall never 1; LU write appears only after wb_regwrite drops.
